adder_delay_meter: RTL

- Measurement sequencer that sits directly upstream of the instrumented adder's ring oscillator.
- On a start request it enables the adder-in-loop ring oscillator and lets it settle. It then counts oscillator rising edges over a programmable window of system clocks and latches the result.
- It raises done and ready, which are routed to mprj_io[9] and mprj_io[8].
- Firmware reads count over the user-project register interface.

---
 rtl/adder_delay_meter_if.sv | 34 +++
 rtl/adder_delay_meter.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/adder_delay_meter_if.sv
// Purpose : firmware-facing request/result bundle of the adder delay meter.
// Latency : none, wires only.
// Backpres: start is honoured only while ready is high; it is never queued.
interface adder_delay_meter_if #(
    parameter int CNT_W = 32,
    parameter int WIN_W = 16
);
    logic             start;
    logic [WIN_W-1:0] window;
    logic             ready;
    logic             done;
    logic [CNT_W-1:0] count;
    logic             overflow;

    // Requester side: issues start/window, observes status and result
    modport master (
        output start,
        output window,
        input  ready,
        input  done,
        input  count,
        input  overflow
    );

    // Meter side: accepts requests, publishes status and result
    modport slave (
        input  start,
        input  window,
        output ready,
        output done,
        output count,
        output overflow
    );
endinterface

// File: rtl/adder_delay_meter.sv
// Purpose : ring-oscillator edge counter that measures adder loop delay over a window.
// Latency : start at edge k -> ring_en k+1..k+SETTLE+window, done at k+SETTLE+window+3.
// Backpres: ready low from acceptance until done; start while busy is dropped.
// Option  : define ADM_BOTH_EDGES_EN to count rising and falling ring edges.
module adder_delay_meter #(
    parameter int CNT_W  = 32,
    parameter int WIN_W  = 16,
    parameter int SETTLE = 4
) (
    input  logic             clk,
    input  logic             RSTB,
    input  logic             ring_in,
    output logic             ring_en,
    adder_delay_meter_if.slave bus
);

    // Settle counter holds SETTLE-1 down to 0, so it needs at least one bit.
    localparam int               SET_W    = (SETTLE < 2) ? 1 : $clog2(SETTLE);
    localparam logic [SET_W-1:0] SET_LOAD = SET_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARM   = 3'd1,
        MEAS  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t           state_q;
    logic [SET_W-1:0] set_q;
    logic [WIN_W-1:0] win_q;
    logic             drain_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             ovf_q;
    logic             ovf_d;
    logic             ring_en_q;
    logic             ready_q;
    logic             done_q;

    logic [1:0]       sync_q;
    logic             prev_q;
    logic             ring_edge;
    logic             accept;

    // Bring the free-running ring tap into the clk domain and keep one history bit
    always_ff @(posedge clk) begin
        if (!RSTB) begin
            sync_q <= 2'b00;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], ring_in};
            prev_q <= sync_q[1];
        end
    end

`ifdef ADM_BOTH_EDGES_EN
    assign ring_edge = sync_q[1] ^ prev_q;
`else
    assign ring_edge = sync_q[1] & ~prev_q;
`endif

    // ready_q is only ever high in IDLE/DONE, so it alone qualifies a request.
    assign accept = bus.start & ready_q;

    // Saturating edge counter: cleared on a new request, advanced only in MEAS
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (accept) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if ((state_q == MEAS) && ring_edge) begin
            if (cnt_q == CNT_MAX) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Sequencer with registered outputs; status flags trail the state by one
    // cycle, except that an accepted request drops ready/done on its own edge.
    always_ff @(posedge clk) begin
        if (!RSTB) begin
            state_q   <= IDLE;
            set_q     <= '0;
            win_q     <= '0;
            drain_q   <= 1'b0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            ring_en_q <= 1'b0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            ring_en_q <= (state_q == ARM) || (state_q == MEAS);
            ready_q   <= !accept && ((state_q == IDLE) || (state_q == DONE));
            done_q    <= !accept && (state_q == DONE);

            case (state_q)
                IDLE, DONE: begin
                    if (accept) begin
                        state_q <= ARM;
                        set_q   <= SET_LOAD;
                        win_q   <= bus.window;
                    end
                end
                ARM: begin
                    // Oscillator runs but nothing is counted until it settles.
                    if (set_q == '0) begin
                        if (win_q == '0) begin
                            state_q <= DRAIN;
                            drain_q <= 1'b1;
                        end else begin
                            state_q <= MEAS;
                        end
                    end else begin
                        set_q <= set_q - SET_W'(1);
                    end
                end
                MEAS: begin
                    // win_q counts the remaining measurement cycles including this one.
                    if (win_q == WIN_W'(1)) begin
                        state_q <= DRAIN;
                        drain_q <= 1'b1;
                    end else begin
                        win_q <= win_q - WIN_W'(1);
                    end
                end
                DRAIN: begin
                    // Two idle cycles let the synchronizer empty before done.
                    if (drain_q) begin
                        drain_q <= 1'b0;
                    end else begin
                        state_q <= DONE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ring_en      = ring_en_q;
    assign bus.ready    = ready_q;
    assign bus.done     = done_q;
    assign bus.count    = cnt_q;
    assign bus.overflow = ovf_q;

endmodule
